// File: rtl/sfifo_elastic_skid.sv
`default_nettype none
// ============================================================================
//  Module   : sfifo_elastic_skid
//  Purpose  : Single-clock elastic FIFO with SKID overflow slots. i_ready_out
//             drops at DEPTH entries. Writes are still taken for up to SKID
//             more entries, which absorbs pipelined upstream latency. The
//             depth may be any integer (no power-of-2 assumption). The FIFO
//             also provides an occupancy count, an almost-full flag and a
//             synchronous flush.
//  Ports    : clk               - clock, all logic on posedge
//             rst_n             - asynchronous reset, active-low
//             i_clear           - synchronous flush (overrides read/write)
//             i_data_in         - write data
//             i_write_en        - write request
//             i_ready_out       - registered, 1 = count < DEPTH (advisory)
//             o_data_out        - registered read data (0 when not valid)
//             o_valid_out       - o_data_out valid this cycle
//             o_read_en         - read request
//             o_ready_out       - 1 = FIFO not empty
//             o_almost_full_out - count >= AFULL_THRESH
//             o_count_out       - occupancy
//             o_overflow_out    - sticky dropped-write flag
//  Options  : `define SFIFO_OVERFLOW_CHECK_EN to enable the sticky overflow
//             flag and the simulation $error on a dropped write. When it is
//             undefined, o_overflow_out is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sfifo_elastic_skid #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 4,
    parameter int SKID         = 1,
    parameter int AFULL_THRESH = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_clear,
    input  logic [WIDTH-1:0]                  i_data_in,
    input  logic                              i_write_en,
    output logic                              i_ready_out,
    output logic [WIDTH-1:0]                  o_data_out,
    output logic                              o_valid_out,
    input  logic                              o_read_en,
    output logic                              o_ready_out,
    output logic                              o_almost_full_out,
    output logic [$clog2(DEPTH+SKID+1)-1:0]   o_count_out,
    output logic                              o_overflow_out
);

    localparam int c_TOTAL = DEPTH + SKID;
    // A single-entry FIFO still needs a 1-bit pointer to index the memory.
    localparam int c_PW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_CW    = $clog2(DEPTH + SKID + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(c_TOTAL - 1);

    logic [WIDTH-1:0] r_mem [c_TOTAL];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [c_CW-1:0]  w_count_next;

    // Acceptance depends only on the true occupancy. i_ready_out is a hint to
    // upstream and does not gate anything. A write into a full FIFO is dropped
    // even when a read happens in the same cycle. A read from an empty FIFO is
    // ignored even when a write happens in the same cycle (no fall-through).
    always_comb begin
        w_wr_acc     = i_write_en && (int'(r_count) < c_TOTAL) && !i_clear;
        w_rd_acc     = o_read_en && (r_count != '0) && !i_clear;
        w_count_next = r_count + c_CW'(w_wr_acc) - c_CW'(w_rd_acc);
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            // Explicit wrap at TOTAL-1 so non-power-of-2 depths work.
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
                r_valid  <= 1'b1;
            end else begin
                r_data   <= '0;
                r_valid  <= 1'b0;
            end
            r_count    <= w_count_next;
            r_in_ready <= (int'(w_count_next) < DEPTH);
        end
    end

`ifdef SFIFO_OVERFLOW_CHECK_EN
    logic r_overflow;
    logic w_drop;

    // A flush in the same cycle wins over the drop.
    assign w_drop = i_write_en && (int'(r_count) == c_TOTAL) && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow_out = r_overflow;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && w_drop) begin
            $error("sfifo_elastic_skid: write dropped at full occupancy");
        end
    end
`endif
`else
    assign o_overflow_out = 1'b0;
`endif

    assign i_ready_out       = r_in_ready;
    assign o_data_out        = r_data;
    assign o_valid_out       = r_valid;
    assign o_ready_out       = (r_count != '0);
    assign o_almost_full_out = (int'(r_count) >= AFULL_THRESH);
    assign o_count_out       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_elastic_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfifo_elastic_skid
//  Purpose  : Self-checking bench for sfifo_elastic_skid. dut_a runs with
//             DEPTH=4/SKID=1 and dut_b runs with DEPTH=3/SKID=2 for the
//             pointer-wrap sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_elastic_skid;

`ifdef SFIFO_OVERFLOW_CHECK_EN
    localparam logic c_OVF = 1'b1;
`else
    localparam logic c_OVF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // dut_a signals
    logic       a_clear, a_we, a_re;
    logic [7:0] a_din;
    logic       a_in_ready, a_valid, a_o_ready, a_afull, a_ovf;
    logic [7:0] a_dout;
    logic [2:0] a_count;

    // dut_b signals
    logic       b_clear, b_we, b_re;
    logic [7:0] b_din;
    logic       b_in_ready, b_valid, b_o_ready, b_afull, b_ovf;
    logic [7:0] b_dout;
    logic [2:0] b_count;

    sfifo_elastic_skid #(.WIDTH(8), .DEPTH(4), .SKID(1), .AFULL_THRESH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_clear(a_clear), .i_data_in(a_din),
        .i_write_en(a_we), .i_ready_out(a_in_ready), .o_data_out(a_dout),
        .o_valid_out(a_valid), .o_read_en(a_re), .o_ready_out(a_o_ready),
        .o_almost_full_out(a_afull), .o_count_out(a_count), .o_overflow_out(a_ovf)
    );

    sfifo_elastic_skid #(.WIDTH(8), .DEPTH(3), .SKID(2), .AFULL_THRESH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_clear(b_clear), .i_data_in(b_din),
        .i_write_en(b_we), .i_ready_out(b_in_ready), .o_data_out(b_dout),
        .o_valid_out(b_valid), .o_read_en(b_re), .o_ready_out(b_o_ready),
        .o_almost_full_out(b_afull), .o_count_out(b_count), .o_overflow_out(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       we;
        logic [7:0] din;
        logic       re;
        int         count;
        logic       rdy;
        logic       af;
        logic       valid;
        logic [7:0] data;
        logic       ovf;   // 1 = overflow expected when the check is built in
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic clr, input logic we, input logic [7:0] din,
                       input logic re, input int count, input logic rdy,
                       input logic af, input logic valid, input logic [7:0] data,
                       input logic ovf);
        vec_t v;
        v.clr = clr; v.we = we; v.din = din; v.re = re; v.count = count;
        v.rdy = rdy; v.af = af; v.valid = valid; v.data = data; v.ovf = ovf;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, " in_ready"}, 32'(a_in_ready), 32'd1);
        chk({tag, " o_ready"},  32'(a_o_ready),  32'd0);
        chk({tag, " count"},    32'(a_count),    32'd0);
        chk({tag, " valid"},    32'(a_valid),    32'd0);
        chk({tag, " data"},     32'(a_dout),     32'd0);
        chk({tag, " overflow"}, 32'(a_ovf),      32'd0);
    endtask

    logic [7:0] mq[$];   // model FIFO contents
    logic [7:0] sb[$];   // expected read data, in order
    int  peak;
    int  got;
    logic rd_ok, wr_ok;

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_we = 0; a_re = 0; a_din = '0;
        b_clear = 0; b_we = 0; b_re = 0; b_din = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_a_reset("reset");

        // Asynchronous reset in the middle of a burst, with valid output data.
        a_we = 1; a_din = 8'hE1; tick();
        a_din = 8'hE2; tick();
        a_din = 8'hE3; a_re = 1; tick();
        chk("burst valid", 32'(a_valid), 32'd1);
        chk("burst data",  32'(a_dout),  32'hE1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_a_reset("async reset");
        a_we = 0; a_re = 0; a_din = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Skid fill and drop of the write at full occupancy.
        add(0,1,8'h11,0, 1,1,0,0,8'h00,0);
        add(0,1,8'h22,0, 2,1,0,0,8'h00,0);
        add(0,1,8'h33,0, 3,1,1,0,8'h00,0);
        add(0,1,8'h44,0, 4,0,1,0,8'h00,0);
        add(0,1,8'h55,0, 5,0,1,0,8'h00,0);
        add(0,1,8'h66,0, 5,0,1,0,8'h00,1);
        // Drain.
        add(0,0,8'h00,1, 4,0,1,1,8'h11,1);
        add(0,0,8'h00,1, 3,1,1,1,8'h22,1);
        add(0,0,8'h00,1, 2,1,0,1,8'h33,1);
        add(0,0,8'h00,1, 1,1,0,1,8'h44,1);
        add(0,0,8'h00,1, 0,1,0,1,8'h55,1);
        add(0,0,8'h00,1, 0,1,0,0,8'h00,1);
        // Simultaneous read and write at count 2, then at count 0.
        add(0,1,8'hA1,0, 1,1,0,0,8'h00,1);
        add(0,1,8'hA2,0, 2,1,0,0,8'h00,1);
        add(0,1,8'hA3,1, 2,1,0,1,8'hA1,1);
        add(0,0,8'h00,1, 1,1,0,1,8'hA2,1);
        add(0,0,8'h00,1, 0,1,0,1,8'hA3,1);
        add(0,1,8'hA5,1, 1,1,0,0,8'h00,1);
        add(0,0,8'h00,1, 0,1,0,1,8'hA5,1);
        // Flush at count 4 with a concurrent write.
        add(0,1,8'hB1,0, 1,1,0,0,8'h00,1);
        add(0,1,8'hB2,0, 2,1,0,0,8'h00,1);
        add(0,1,8'hB3,0, 3,1,1,0,8'h00,1);
        add(0,1,8'hB4,0, 4,0,1,0,8'h00,1);
        add(1,1,8'hC0,0, 0,1,0,0,8'h00,0);
        add(0,0,8'h00,1, 0,1,0,0,8'h00,0);
        add(0,1,8'hD1,1, 1,1,0,0,8'h00,0);
        add(0,0,8'h00,1, 0,1,0,1,8'hD1,0);

        for (int i = 0; i < vt.size(); i++) begin
            a_clear = vt[i].clr; a_we = vt[i].we; a_din = vt[i].din; a_re = vt[i].re;
            tick();
            chk($sformatf("v%0d count", i),    32'(a_count),    32'(vt[i].count));
            chk($sformatf("v%0d in_ready", i), 32'(a_in_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d afull", i),    32'(a_afull),    32'(vt[i].af));
            chk($sformatf("v%0d o_ready", i),  32'(a_o_ready),  32'(vt[i].count != 0));
            chk($sformatf("v%0d valid", i),    32'(a_valid),    32'(vt[i].valid));
            chk($sformatf("v%0d data", i),     32'(a_dout),     32'(vt[i].data));
            chk($sformatf("v%0d overflow", i), 32'(a_ovf),      32'(vt[i].ovf & c_OVF));
        end
        a_clear = 0; a_we = 0; a_re = 0; a_din = '0;

        // Pointer wrap on dut_b: reads lag writes by two cycles.
        peak = 0;
        got  = 0;
        for (int k = 0; k < 14; k++) begin
            b_we  = (k < 12);
            b_din = 8'(k + 1);
            b_re  = (k >= 2);
            rd_ok = b_re && (mq.size() != 0);
            wr_ok = b_we && (mq.size() < 5);
            if (rd_ok) sb.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(b_din);
            tick();
            chk($sformatf("wrap%0d count", k), 32'(b_count), 32'(mq.size()));
            chk($sformatf("wrap%0d valid", k), 32'(b_valid), 32'(rd_ok));
            if (int'(b_count) > peak) peak = int'(b_count);
            if (b_valid) begin
                if (sb.size() == 0) begin
                    chk($sformatf("wrap%0d unexpected output", k), 32'(b_dout), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("wrap%0d data", k), 32'(b_dout), 32'(sb.pop_front()));
                    got++;
                end
            end
        end
        b_we = 0; b_re = 0; b_din = '0;
        chk("wrap peak count", 32'(peak), 32'd2);
        chk("wrap outputs",    32'(got),  32'd12);
        chk("wrap leftover",   32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
